// File: rtl/fpmul_writeback.sv
// fpmul_writeback: merges SD and Q multiplier results into one ordered FIFO
// and presents them one at a time on a register-file write port.
module fpmul_writeback #(
  parameter int DEPTH = 8
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic           RDYSD,
  input  logic [3:0]     DSTSD,
  input  logic [63:0]    RSD,
  input  logic           SR,
  input  logic           ZEROSD,
  input  logic           SIGNSD,
  input  logic           INFSD,
  input  logic           NANSD,
  input  logic           RDYQ,
  input  logic [3:0]     DSTQ,
  input  logic [127:0]   RQ,
  input  logic           ZEROQ,
  input  logic           SIGNQ,
  input  logic           INFQ,
  input  logic           NANQ,
  output logic           WREQ,
  input  logic           WACK,
  output logic [3:0]     WDST,
  output logic [127:0]   WDATA,
  output logic [1:0]     WSIZE,
  output logic [3:0]     WFLAGS,
  output logic [3:0]     PEND,
  output logic           OVF
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  typedef struct packed {
    logic [127:0] data;
    logic [3:0]   dst;
    logic [1:0]   size;
    logic [3:0]   flags;
  } entry_t;
  entry_t mem_q [DEPTH];
  entry_t q_ent, sd_ent, out_q, out_d;
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d, free;
  logic wreq_q, wreq_d, ovf_q, ovf_d, acc_rq, acc_rsd, pop;
  assign q_ent  = {RQ, DSTQ, 2'b10, ZEROQ, SIGNQ, INFQ, NANQ};
  assign sd_ent = {64'd0, RSD, DSTSD, {1'b0, SR}, ZEROSD, SIGNSD, INFSD, NANSD};
  // Space is judged before this edge's pop; Q is older so it claims a slot first.
  always_comb begin
    free    = CW'(DEPTH) - cnt_q;
    acc_rq  = RDYQ && (free != '0);
    acc_rsd = RDYSD && (acc_rq ? (free >= CW'(2)) : (free != '0));
    pop     = (cnt_q != '0) && (!wreq_q || WACK);
    wp_d    = wp_q + AW'(acc_rq) + AW'(acc_rsd);
    rp_d    = rp_q + AW'(pop);
    cnt_d   = cnt_q + CW'(acc_rq) + CW'(acc_rsd) - CW'(pop);
    ovf_d   = ovf_q || (RDYQ && !acc_rq) || (RDYSD && !acc_rsd);
    out_d   = pop ? mem_q[rp_q] : out_q;
    wreq_d  = pop ? 1'b1 : (wreq_q && !WACK);
  end
  always_ff @(posedge CLK) begin
    if (acc_rq) mem_q[wp_q] <= q_ent;
    if (acc_rsd) mem_q[wp_q + AW'(acc_rq)] <= sd_ent;
  end
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wp_q   <= '0;
      rp_q   <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      wreq_q <= 1'b0;
      out_q  <= '0;
    end else begin
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      wreq_q <= wreq_d;
      out_q  <= out_d;
    end
  end
  assign WREQ   = wreq_q;
  assign WDST   = out_q.dst;
  assign WDATA  = out_q.data;
  assign WSIZE  = out_q.size;
  assign WFLAGS = out_q.flags;
  assign PEND   = 4'(cnt_q);
  assign OVF    = ovf_q;
endmodule

// File: tb/tb_fpmul_writeback.sv
// tb_fpmul_writeback: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_fpmul_writeback;
  logic CLK = 0, RESET = 0;
  logic RDYSD = 0, SR = 0, ZEROSD = 0, SIGNSD = 0, INFSD = 0, NANSD = 0;
  logic [3:0] DSTSD = 0;
  logic [63:0] RSD = 0;
  logic RDYQ = 0, ZEROQ = 0, SIGNQ = 0, INFQ = 0, NANQ = 0;
  logic [3:0] DSTQ = 0;
  logic [127:0] RQ = 0;
  logic WREQ, WACK = 1;
  logic [3:0] WDST, WFLAGS, PEND;
  logic [127:0] WDATA;
  logic [1:0] WSIZE;
  logic OVF;
  fpmul_writeback dut (
    .CLK(CLK), .RESET(RESET),
    .RDYSD(RDYSD), .DSTSD(DSTSD), .RSD(RSD), .SR(SR),
    .ZEROSD(ZEROSD), .SIGNSD(SIGNSD), .INFSD(INFSD), .NANSD(NANSD),
    .RDYQ(RDYQ), .DSTQ(DSTQ), .RQ(RQ),
    .ZEROQ(ZEROQ), .SIGNQ(SIGNQ), .INFQ(INFQ), .NANQ(NANQ),
    .WREQ(WREQ), .WACK(WACK), .WDST(WDST), .WDATA(WDATA),
    .WSIZE(WSIZE), .WFLAGS(WFLAGS), .PEND(PEND), .OVF(OVF)
  );
  always #5 CLK = ~CLK;
  int checks = 0, errors = 0;
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask
  // Reference: a plain queue of {data,dst,size,flags} plus one output slot.
  logic [137:0] mq[$];
  logic [137:0] m_out = '0;
  logic m_wreq = 0, m_ovf = 0;
  always @(posedge CLK or negedge RESET) begin
    int free;
    if (!RESET) begin
      mq.delete();
      m_out = '0;
      m_wreq = 0;
      m_ovf = 0;
    end else begin
      free = 8 - mq.size();
      if (mq.size() > 0 && (!m_wreq || WACK)) begin
        m_out = mq.pop_front();
        m_wreq = 1;
      end else if (m_wreq && WACK) m_wreq = 0;
      if (RDYQ) begin
        if (free > 0) begin
          mq.push_back({RQ, DSTQ, 2'b10, ZEROQ, SIGNQ, INFQ, NANQ});
          free--;
        end else m_ovf = 1;
      end
      if (RDYSD) begin
        if (free > 0) begin
          mq.push_back({64'd0, RSD, DSTSD, SR ? 2'b01 : 2'b00, ZEROSD, SIGNSD, INFSD, NANSD});
          free--;
        end else m_ovf = 1;
      end
    end
  end
  always @(negedge CLK) begin
    chk("m_wreq", {127'd0, WREQ}, {127'd0, m_wreq});
    chk("m_pend", {124'd0, PEND}, 128'(mq.size()));
    chk("m_ovf", {127'd0, OVF}, {127'd0, m_ovf});
    if (m_wreq) begin
      chk("m_wdata", WDATA, m_out[137:10]);
      chk("m_wdst", {124'd0, WDST}, {124'd0, m_out[9:6]});
      chk("m_wsize", {126'd0, WSIZE}, {126'd0, m_out[5:4]});
      chk("m_wflags", {124'd0, WFLAGS}, {124'd0, m_out[3:0]});
    end
  end
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic sd(input logic [3:0] dst, input logic [63:0] d, input logic sr, input logic [3:0] fl);
    RDYSD = 1; DSTSD = dst; RSD = d; SR = sr;
    {ZEROSD, SIGNSD, INFSD, NANSD} = fl;
    tick();
    RDYSD = 0;
  endtask
  task automatic do_reset();
    RESET = 0;
    tick();
    RESET = 1;
  endtask
  initial begin
    repeat (2) tick();
    chk("rst_wreq", {127'd0, WREQ}, 0);
    chk("rst_pend", {124'd0, PEND}, 0);
    chk("rst_wdata", WDATA, 0);
    RESET = 1;
    // single SD result, two-edge latency
    sd(4'd3, 64'h3FF0000000000000, 1'b1, 4'b0000);
    chk("lat_no_bypass", {127'd0, WREQ}, 0);
    tick();
    chk("sd_wreq", {127'd0, WREQ}, 1);
    chk("sd_wdst", {124'd0, WDST}, 3);
    chk("sd_wsize", {126'd0, WSIZE}, 1);
    chk("sd_wdata", WDATA, 128'h3FF0000000000000);
    chk("sd_wflags", {124'd0, WFLAGS}, 0);
    tick();
    chk("sd_one_cycle", {127'd0, WREQ}, 0);
    // simultaneous Q and SD: Q first
    RDYQ = 1; DSTQ = 5; RQ = 128'h0123456789ABCDEF_FEDCBA9876543210;
    {ZEROQ, SIGNQ, INFQ, NANQ} = 4'b0100;
    sd(4'd5, 64'hAAAABBBBCCCCDDDD, 1'b0, 4'b0010);
    RDYQ = 0;
    tick();
    chk("dual_q_size", {126'd0, WSIZE}, 2);
    chk("dual_q_dst", {124'd0, WDST}, 5);
    chk("dual_q_flags", {124'd0, WFLAGS}, 4'b0100);
    tick();
    chk("dual_sd_wreq", {127'd0, WREQ}, 1);
    chk("dual_sd_size", {126'd0, WSIZE}, 0);
    chk("dual_sd_data", WDATA, 128'hAAAABBBBCCCCDDDD);
    tick();
    chk("dual_done", {127'd0, WREQ}, 0);
    // stall while the FIFO overflows
    WACK = 0;
    sd(4'd15, 64'h00000000DEADBEEF, 1'b0, 4'b1001);
    tick();
    chk("stall_wreq", {127'd0, WREQ}, 1);
    chk("stall_dst", {124'd0, WDST}, 15);
    for (int i = 0; i < 9; i++) begin
      sd(4'(i), 64'(i) << 8, 1'(i), 4'(i));
      chk("stall_hold_wreq", {127'd0, WREQ}, 1);
      chk("stall_hold_data", WDATA, 128'hDEADBEEF);
      chk("stall_hold_flags", {124'd0, WFLAGS}, 4'b1001);
    end
    chk("ovf_pend", {124'd0, PEND}, 8);
    chk("ovf_set", {127'd0, OVF}, 1);
    WACK = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("drain_wreq", {127'd0, WREQ}, 1);
      chk("drain_dst", {124'd0, WDST}, 128'(i));
    end
    tick();
    chk("drain_end", {127'd0, WREQ}, 0);
    chk("ovf_sticky", {127'd0, OVF}, 1);
    // one free slot, both arrive: Q kept, SD dropped
    do_reset();
    chk("ovf_cleared", {127'd0, OVF}, 0);
    WACK = 0;
    sd(4'd9, 64'h9, 1'b1, 4'b0);
    for (int i = 0; i < 7; i++) sd(4'(i), 64'(i), 1'b1, 4'b0);
    RDYQ = 1; DSTQ = 10; RQ = 128'hA0;
    {ZEROQ, SIGNQ, INFQ, NANQ} = 4'b0;
    sd(4'd11, 64'hB0, 1'b1, 4'b0);
    RDYQ = 0;
    chk("slot1_pend", {124'd0, PEND}, 8);
    chk("slot1_ovf", {127'd0, OVF}, 1);
    chk("slot1_head", {124'd0, WDST}, 9);
    WACK = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("slot1_dst", {124'd0, WDST}, (i == 7) ? 128'd10 : 128'(i));
    end
    chk("slot1_q_size", {126'd0, WSIZE}, 2);
    tick();
    chk("slot1_end", {127'd0, WREQ}, 0);
    // asynchronous reset mid-stream
    do_reset();
    WACK = 0;
    for (int i = 1; i <= 5; i++) sd(4'(i), 64'(i), 1'b0, 4'b0);
    chk("mid_pend", {124'd0, PEND}, 4);
    chk("mid_wreq", {127'd0, WREQ}, 1);
    #3 RESET = 0;
    #1;
    chk("async_wreq", {127'd0, WREQ}, 0);
    chk("async_pend", {124'd0, PEND}, 0);
    chk("async_wdata", WDATA, 0);
    chk("async_wdst", {124'd0, WDST}, 0);
    tick();
    RESET = 1;
    WACK = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_idle", {127'd0, WREQ}, 0);
    end
    sd(4'd7, 64'h77, 1'b1, 4'b0);
    tick();
    chk("post_rst_wreq", {127'd0, WREQ}, 1);
    chk("post_rst_dst", {124'd0, WDST}, 7);
    tick();
    chk("post_rst_end", {127'd0, WREQ}, 0);
    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
